// File: rtl/cache_pkg.sv
// Shared constants, state encoding and address helpers for the 4-way cache lookup/replacement controller.
package cache_pkg;

    localparam int unsigned WAYS        = 4;
    localparam int unsigned TAG_BITS    = 18;
    localparam int unsigned SET_BITS    = 12;
    localparam int unsigned OFFSET_BITS = 2;
    localparam int unsigned ADDR_BITS   = TAG_BITS + SET_BITS + OFFSET_BITS;
    localparam int unsigned SETS        = 1 << SET_BITS;
    localparam int unsigned PLRU_BITS   = 3;

    localparam int unsigned SET_LSB = OFFSET_BITS;
    localparam int unsigned TAG_LSB = OFFSET_BITS + SET_BITS;

    // Tree bit positions: root chooses the pair, LO/HI choose within {0,1}/{2,3}.
    localparam int unsigned PLRU_ROOT = 0;
    localparam int unsigned PLRU_LO   = 1;
    localparam int unsigned PLRU_HI   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_REFILL,
        ST_FILL,
        ST_RESP
    } state_e;

    function automatic logic [ADDR_BITS-1:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                                       input logic [SET_BITS-1:0] set);
        return {tag, set, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/plru_tree_4.sv
// Tree pseudo-LRU for four ways: victim from the current bits, and the bits after an access.
module plru_tree_4
    import cache_pkg::*;
(
    input  logic [PLRU_BITS-1:0] i_bits,
    input  logic [WAYS-1:0]      i_access,
    output logic [WAYS-1:0]      o_victim_c,
    output logic [PLRU_BITS-1:0] o_next_c
);

    always_comb begin
        o_victim_c = '0;
        if (!i_bits[PLRU_ROOT]) begin
            o_victim_c = i_bits[PLRU_LO] ? 4'b0010 : 4'b0001;
        end else begin
            o_victim_c = i_bits[PLRU_HI] ? 4'b1000 : 4'b0100;
        end
    end

    // Accessing a way points the tree away from it.
    always_comb begin
        o_next_c = i_bits;
        if (i_access[0]) begin
            o_next_c[PLRU_ROOT] = 1'b1;
            o_next_c[PLRU_LO]   = 1'b1;
        end else if (i_access[1]) begin
            o_next_c[PLRU_ROOT] = 1'b1;
            o_next_c[PLRU_LO]   = 1'b0;
        end else if (i_access[2]) begin
            o_next_c[PLRU_ROOT] = 1'b0;
            o_next_c[PLRU_HI]   = 1'b1;
        end else if (i_access[3]) begin
            o_next_c[PLRU_ROOT] = 1'b0;
            o_next_c[PLRU_HI]   = 1'b0;
        end
    end

endmodule

// File: rtl/cache_way_ctrl.sv
// Lookup and replacement controller for a 4-way set-associative cache:
// tag compare, victim choice, write-back/refill sequencing and per-set PLRU state.
module cache_way_ctrl
    import cache_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [ADDR_BITS-1:0]      i_req_addr,
    output logic [SET_BITS-1:0]       o_set_idx,
    input  logic [WAYS-1:0]           i_way_valid,
    input  logic [WAYS-1:0]           i_way_dirty,
    input  logic [WAYS*TAG_BITS-1:0]  i_way_tag,
    output logic [WAYS-1:0]           o_way_sel,
    output logic                      o_fill_we,
    output logic                      o_mem_req,
    output logic                      o_mem_wr,
    output logic [ADDR_BITS-1:0]      o_mem_addr,
    input  logic                      i_mem_ack,
    output logic                      o_resp_valid,
    output logic                      o_resp_hit
);

    state_e                r_state;
    logic [TAG_BITS-1:0]   r_tag;
    logic [SET_BITS-1:0]   r_set;
    logic [WAYS-1:0]       r_way;
    logic [PLRU_BITS-1:0]  r_plru [SETS];

    logic [WAYS-1:0]       w_hit;
    logic [WAYS-1:0]       w_hit_sel;
    logic [WAYS-1:0]       w_inv;
    logic [WAYS-1:0]       w_inv_sel;
    logic [WAYS-1:0]       w_plru_victim;
    logic [WAYS-1:0]       w_victim;
    logic                  w_victim_dirty;
    logic [TAG_BITS-1:0]   w_victim_tag;
    logic [PLRU_BITS-1:0]  w_plru_cur;
    logic [PLRU_BITS-1:0]  w_plru_next;
    logic                  w_unused_offset;

    assign w_unused_offset = ^i_req_addr[OFFSET_BITS-1:0];

    // Arrays are addressed straight from the request while idle so data is ready in LOOKUP.
    assign o_set_idx = (r_state == ST_IDLE) ? i_req_addr[SET_LSB +: SET_BITS] : r_set;

    always_comb begin
        w_hit = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_hit[w] = i_way_valid[w] && (i_way_tag[w*TAG_BITS +: TAG_BITS] == r_tag);
        end
    end

    // Isolate the lowest set bit so multiple hits/invalids resolve to the lowest way.
    assign w_hit_sel = w_hit & (~w_hit + WAYS'(1));
    assign w_inv     = ~i_way_valid;
    assign w_inv_sel = w_inv & (~w_inv + WAYS'(1));

    assign w_plru_cur     = r_plru[r_set];
    assign w_victim       = (|w_inv) ? w_inv_sel : w_plru_victim;
    assign w_victim_dirty = |(w_victim & i_way_valid & i_way_dirty);

    always_comb begin
        w_victim_tag = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w_victim[w]) w_victim_tag = i_way_tag[w*TAG_BITS +: TAG_BITS];
        end
    end

    plru_tree_4 u_plru (
        .i_bits     (w_plru_cur),
        .i_access   (r_way),
        .o_victim_c (w_plru_victim),
        .o_next_c   (w_plru_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned s = 0; s < SETS; s++) r_plru[s] <= '0;
        end else if (r_state == ST_RESP) begin
            r_plru[r_set] <= w_plru_next;
        end
    end

    // Controller FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_tag        <= '0;
            r_set        <= '0;
            r_way        <= '0;
            o_req_ready  <= 1'b1;
            o_way_sel    <= '0;
            o_fill_we    <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_wr     <= 1'b0;
            o_mem_addr   <= '0;
            o_resp_valid <= 1'b0;
            o_resp_hit   <= 1'b0;
        end else begin
            o_way_sel    <= '0;
            o_fill_we    <= 1'b0;
            o_resp_valid <= 1'b0;
            o_resp_hit   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_tag       <= i_req_addr[TAG_LSB +: TAG_BITS];
                        r_set       <= i_req_addr[SET_LSB +: SET_BITS];
                        o_req_ready <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (|w_hit) begin
                        r_way        <= w_hit_sel;
                        o_way_sel    <= w_hit_sel;
                        o_resp_valid <= 1'b1;
                        o_resp_hit   <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_way     <= w_victim;
                        o_mem_req <= 1'b1;
                        if (w_victim_dirty) begin
                            o_mem_wr   <= 1'b1;
                            o_mem_addr <= line_addr(w_victim_tag, r_set);
                            r_state    <= ST_WB;
                        end else begin
                            o_mem_wr   <= 1'b0;
                            o_mem_addr <= line_addr(r_tag, r_set);
                            r_state    <= ST_REFILL;
                        end
                    end
                end
                ST_WB: begin
                    if (i_mem_ack) begin
                        o_mem_wr   <= 1'b0;
                        o_mem_addr <= line_addr(r_tag, r_set);
                        r_state    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (i_mem_ack) begin
                        o_mem_req  <= 1'b0;
                        o_mem_addr <= '0;
                        o_fill_we  <= 1'b1;
                        o_way_sel  <= r_way;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    o_way_sel    <= r_way;
                    o_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    o_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    o_req_ready <= 1'b1;
                    o_mem_req   <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Directed bench for cache_way_ctrl: reset, cold miss, hits, dirty write-back, PLRU order, reset mid-refill.
module tb_cache_way_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [11:0] set_idx;
    logic [3:0]  way_valid;
    logic [3:0]  way_dirty;
    logic [71:0] way_tag;
    logic [3:0]  way_sel;
    logic        fill_we;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        resp_valid;
    logic        resp_hit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_way_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .o_set_idx    (set_idx),
        .i_way_valid  (way_valid),
        .i_way_dirty  (way_dirty),
        .i_way_tag    (way_tag),
        .o_way_sel    (way_sel),
        .o_fill_we    (fill_we),
        .o_mem_req    (mem_req),
        .o_mem_wr     (mem_wr),
        .o_mem_addr   (mem_addr),
        .i_mem_ack    (mem_ack),
        .o_resp_valid (resp_valid),
        .o_resp_hit   (resp_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [17:0] tag, input logic [11:0] set);
        return {tag, set, 2'b00};
    endfunction

    function automatic logic [71:0] tags(input logic [17:0] t3, input logic [17:0] t2,
                                         input logic [17:0] t1, input logic [17:0] t0);
        return {t3, t2, t1, t0};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ready"}, 32'(req_ready),  32'd1);
        check({tag, ".memreq"}, 32'(mem_req),   32'd0);
        check({tag, ".resp"},  32'(resp_valid), 32'd0);
        check({tag, ".waysel"}, 32'(way_sel),   32'd0);
        check({tag, ".fill"},  32'(fill_we),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; mem_ack = 1'b0;
        way_valid = '0; way_dirty = '0; way_tag = '0;
        tick(); tick();
        check_idle_outputs("rst_hold");
        rst = 1'b0;
        tick();
        check_idle_outputs("rst_rel");

        // Set index follows the request address while idle.
        req_addr = 32'h0000_ABCD;
        #1;
        check("idle_setidx", 32'(set_idx), 32'h0AF3);

        // Cold miss: every way invalid, way0 filled.
        send(32'h0000_1234);
        check("cold.setidx", 32'(set_idx), 32'h048D);
        check("cold.ready", 32'(req_ready), 32'd0);
        tick();
        check("cold.memreq", 32'(mem_req), 32'd1);
        check("cold.memwr", 32'(mem_wr), 32'd0);
        check("cold.memaddr", mem_addr, 32'h0000_1234);
        tick(); tick();
        check("cold.hold_req", 32'(mem_req), 32'd1);
        check("cold.hold_addr", mem_addr, 32'h0000_1234);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("cold.fill_we", 32'(fill_we), 32'd1);
        check("cold.fill_way", 32'(way_sel), 32'b0001);
        check("cold.fill_memreq", 32'(mem_req), 32'd0);
        tick();
        check("cold.resp", 32'(resp_valid), 32'd1);
        check("cold.hit", 32'(resp_hit), 32'd0);
        check("cold.resp_way", 32'(way_sel), 32'b0001);
        check("cold.resp_fill", 32'(fill_we), 32'd0);
        tick();
        check_idle_outputs("cold.done");

        // Hit in way2; a stray ack must be ignored.
        way_valid = 4'b1111; way_dirty = 4'b1111;
        way_tag   = tags(18'h13, 18'h2A, 18'h11, 18'h10);
        mem_ack   = 1'b1;
        send(mk(18'h2A, 12'h100));
        check("hit.lookup_resp", 32'(resp_valid), 32'd0);
        check("hit.lookup_memreq", 32'(mem_req), 32'd0);
        tick();
        check("hit.resp", 32'(resp_valid), 32'd1);
        check("hit.hit", 32'(resp_hit), 32'd1);
        check("hit.way", 32'(way_sel), 32'b0100);
        check("hit.memreq", 32'(mem_req), 32'd0);
        tick();
        mem_ack = 1'b0;
        check_idle_outputs("hit.done");

        // Two matching ways resolve to the lower index.
        way_tag = tags(18'h55, 18'h13, 18'h55, 18'h10);
        send(mk(18'h55, 12'h101));
        tick();
        check("multihit.way", 32'(way_sel), 32'b0010);
        check("multihit.hit", 32'(resp_hit), 32'd1);
        tick();

        // Dirty PLRU victim in set 5 goes through write-back first.
        way_valid = 4'b1111; way_dirty = 4'b0001;
        way_tag   = tags(18'h4, 18'h3, 18'h2, 18'h3FFFF);
        send(mk(18'h1, 12'h005));
        tick();
        check("wb.memreq", 32'(mem_req), 32'd1);
        check("wb.memwr", 32'(mem_wr), 32'd1);
        check("wb.memaddr", mem_addr, 32'hFFFF_C014);
        tick();
        check("wb.hold_addr", mem_addr, 32'hFFFF_C014);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("wb.refill_req", 32'(mem_req), 32'd1);
        check("wb.refill_wr", 32'(mem_wr), 32'd0);
        check("wb.refill_addr", mem_addr, 32'h0000_4014);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("wb.fill_way", 32'(way_sel), 32'b0001);
        check("wb.fill_we", 32'(fill_we), 32'd1);
        tick();
        check("wb.resp_hit", 32'(resp_hit), 32'd0);
        tick();

        // PLRU ordering: hit way0, hit way2, then a miss evicts way1.
        way_valid = 4'b1111; way_dirty = 4'b0000;
        way_tag   = tags(18'h13, 18'h12, 18'h11, 18'h10);
        send(mk(18'h10, 12'h200)); tick();
        check("plru.hit0", 32'(way_sel), 32'b0001);
        tick();
        send(mk(18'h12, 12'h200)); tick();
        check("plru.hit2", 32'(way_sel), 32'b0100);
        tick();
        send(mk(18'h20, 12'h200)); tick();
        check("plru.miss_wr", 32'(mem_wr), 32'd0);
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("plru.victim", 32'(way_sel), 32'b0010);
        tick(); tick();

        // Reset while refilling drops the transaction and clears PLRU.
        way_valid = 4'b0000;
        send(mk(18'h30, 12'h200)); tick();
        check("rstref.memreq_before", 32'(mem_req), 32'd1);
        rst = 1'b1; tick();
        check_idle_outputs("rstref.first");
        tick(); rst = 1'b0;
        tick();
        check_idle_outputs("rstref.after");
        way_valid = 4'b1111;
        send(mk(18'h40, 12'h200)); tick();
        mem_ack = 1'b1; tick(); mem_ack = 1'b0;
        check("rstref.cold_victim", 32'(way_sel), 32'b0001);
        tick(); tick();
        check("rstref.final_ready", 32'(req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_way_ctrl.md
Name: cache_way_ctrl

Overview:
- Lookup and replacement controller for the 4-way set-associative cache.
- Accepts one CPU request at a time, compares the request tag against the four ways of the indexed set, and produces the one-hot way select that steers the way data mux.
- On a miss it picks a victim (first invalid way, else tree pseudo-LRU), sequences write-back and refill through the memory handshake, then writes the filled way.
- Owns the per-set PLRU state.

Parameters:
- WAYS, 4, number of ways; fixed at 4, other values unsupported.
- TAG_BITS, 18, tag field width.
- SET_BITS, 12, set index width.
- OFFSET_BITS, 2, byte offset within a line (4-byte line).
- ADDR_BITS, 32, address width; must equal TAG_BITS+SET_BITS+OFFSET_BITS.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  CPU request valid
- o_req_ready  out  1  controller idle; request accepted when valid&ready
- i_req_addr  in  ADDR_BITS  request byte address
- o_set_idx  out  SET_BITS  set index to tag/data arrays
- i_way_valid  in  4  valid bit per way for o_set_idx
- i_way_dirty  in  4  dirty bit per way
- i_way_tag  in  4*TAG_BITS  tags packed; way0 in LSBs
- o_way_sel  out  4  one-hot way select to data mux and array write port
- o_fill_we  out  1  write refilled line, request tag, valid=1, dirty=0 into o_way_sel
- o_mem_req  out  1  memory request
- o_mem_wr  out  1  1 = write-back, 0 = refill read
- o_mem_addr  out  ADDR_BITS  line-aligned memory address
- i_mem_ack  in  1  memory transfer complete
- o_resp_valid  out  1  one-cycle response pulse
- o_resp_hit  out  1  response was a hit

Behaviour:
- States: IDLE, LOOKUP, WB, REFILL, FILL, RESP.
- Reset: state=IDLE and all PLRU bits=0. In the cycle after reset, o_req_ready=1 and every other output is 0. o_set_idx follows i_req_addr while IDLE.
- IDLE:
  - o_req_ready=1 and o_set_idx = i_req_addr set field (combinational).
  - On i_req_valid, latch the address and go to LOOKUP.
  - In every other state o_set_idx = the latched set field.
- LOOKUP:
  - Array data is valid this cycle (arrays have 1-cycle read latency).
  - hit[w] = i_way_valid[w] & (tag[w]==req_tag). Multiple hits select the lowest index.
  - On hit: register the hit way and go to RESP.
  - On miss: victim = lowest-index invalid way, else the PLRU victim. Register the victim.
  - If the victim is valid&dirty go to WB, else REFILL.
- WB:
  - o_mem_req=1, o_mem_wr=1, o_mem_addr={victim_tag, set, 0}.
  - Held stable until i_mem_ack, then go to REFILL.
- REFILL:
  - o_mem_req=1, o_mem_wr=0, o_mem_addr={req_tag, set, 0}.
  - Held until i_mem_ack, then go to FILL.
- FILL: o_fill_we=1 and o_way_sel=victim for exactly one cycle, then go to RESP.
- RESP:
  - o_resp_valid=1 and o_way_sel = hit or victim way.
  - o_resp_hit=1 only for the hit path.
  - Update PLRU for the set, then go to IDLE.
- Latency: a hit responds 2 cycles after acceptance. Miss latency is variable.
- o_way_sel is 0 outside FILL and RESP.
- PLRU encoding (3 bits per set, b0 root):
  - b0=0 selects ways {0,1}; b0=1 selects ways {2,3}.
  - b1 picks within {0,1}: 0 = way0, 1 = way1.
  - b2 picks within {2,3}: 0 = way2, 1 = way3.
  - Update on access: way0 sets b0=1,b1=1; way1 sets b0=1,b1=0; way2 sets b0=0,b2=1; way3 sets b0=0,b2=0.
- i_mem_ack outside WB/REFILL is ignored.
- i_req_valid outside IDLE is ignored; there is no queueing.
- There is no response backpressure.
- i_rst in any state: return to IDLE next cycle, drop o_mem_req and the in-flight transaction, issue no response, clear PLRU.

Decomposition:
- Package cache_pkg: state encoding, PLRU bit indices, address field slicing constants, line-address helper function.
- Sub-module plru_tree_4:
  - Combinational victim from 3 PLRU bits.
  - Next-state bits from an accessed one-hot way.
  - The PLRU storage array stays in cache_way_ctrl.

Test Plan:
- Reset: hold i_rst 2 cycles mid-traffic -> o_req_ready=1; o_mem_req, o_resp_valid, o_way_sel, o_fill_we all 0.
- Cold miss: all ways invalid, addr 0x00001234 (set 0x48D, tag 0) -> o_set_idx=0x48D; REFILL with o_mem_addr=0x00001234 and wr=0; ack after 3 cycles -> FILL with o_way_sel=0001; RESP with hit=0.
- Hit: all valid, way2 tag matches -> o_resp_valid 2 cycles after acceptance, o_way_sel=0100, o_resp_hit=1, o_mem_req never asserted.
- Dirty victim: set 5, all valid, PLRU=000, way0 dirty with tag 0x3FFFF -> WB o_mem_addr=0xFFFFC014, wr=1; then REFILL of the request address; FILL way 0001.
- PLRU: set all valid and clean; hit way0, then hit way2, then miss -> victim o_way_sel=0010.
- Reset in REFILL while o_mem_req=1 -> next cycle o_mem_req=0, o_req_ready=1, no o_resp_valid; a new request then behaves as cold PLRU.
